// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit path.
//   DBIT               : byte width, shared by the transmitter and the feeder
//   FIFO_DEPTH_LOG2    : default log2 depth of the feeder byte buffer
//   TIMEOUT_CYCLES_DEF : default watchdog limit for a frame in flight
//   FEED_IDLE/BUSY     : feeder FSM state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DBIT               = 8;
   localparam int FIFO_DEPTH_LOG2    = 4;
   localparam int TIMEOUT_CYCLES_DEF = 100000;

   // Feeder FSM encoding, kept as plain vectors so legacy code that compares
   // against raw state bits keeps working.
   typedef logic [0:0] feed_state_t;
   localparam logic [0:0] FEED_IDLE = 1'b0;
   localparam logic [0:0] FEED_BUSY = 1'b1;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
// Bundles the write port, the status flags and the transmitter handshake of
// the UART feeder.
//   wr_en/wr_data/flush/ovf_clr : producer controls       (master -> slave)
//   full/empty/count/overflow   : buffer status           (slave  -> master)
//   tx_start/tx_data            : launch to transmitter   (slave  -> master)
//   tx_done_tick                : end of frame            (master -> slave)
//   busy/timeout_err            : frame in flight / watchdog abort pulse
// The slave modport is taken by uart_tx_feeder; the master modport by the
// surrounding logic (game logic plus transmitter).
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
   parameter int DATA_W     = DBIT
);

   logic                  wr_en;
   logic [DATA_W-1:0]     wr_data;
   logic                  flush;
   logic                  ovf_clr;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  tx_start;
   logic [DATA_W-1:0]     tx_data;
   logic                  tx_done_tick;
   logic                  busy;
   logic                  timeout_err;

   modport master (
      output wr_en, wr_data, flush, ovf_clr, tx_done_tick,
      input  full, empty, count, overflow, tx_start, tx_data, busy, timeout_err
   );

   modport slave (
      input  wr_en, wr_data, flush, ovf_clr, tx_done_tick,
      output full, empty, count, overflow, tx_start, tx_data, busy, timeout_err
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock byte FIFO with registered read data.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_wr_en      : write strobe (ignored while full or during flush)
//   i_wr_data    : byte to enqueue
//   i_flush      : clear pointers and count at the next edge
//   i_ovf_clr    : clear the sticky overflow flag
//   i_pop        : pop request; o_rd_data is loaded with the head entry
//   o_rd_data    : registered head byte, holds until the next pop
//   o_full       : count == 2**DEPTH_LOG2
//   o_empty      : count == 0
//   o_count      : occupancy
//   o_overflow   : sticky, set by a write attempted while full
// -----------------------------------------------------------------------------
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
   parameter int DATA_W     = DBIT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_wr_en,
   input  logic [DATA_W-1:0]     i_wr_data,
   input  logic                  i_flush,
   input  logic                  i_ovf_clr,
   input  logic                  i_pop,
   output logic [DATA_W-1:0]     o_rd_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_overflow
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [DATA_W-1:0]       r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0]   r_wr_ptr;
   logic [DEPTH_LOG2-1:0]   r_rd_ptr;
   logic [DEPTH_LOG2:0]     r_count;
   logic [DATA_W-1:0]       r_rd_data;
   logic                    r_overflow;

   logic                    w_full;
   logic                    w_empty;
   logic                    w_do_wr;
   logic                    w_do_pop;
   logic                    w_wr_drop;

   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);

   // Flush wins over both ports: a same-cycle write is discarded silently
   // (no overflow) and a same-cycle pop does not happen.
   assign w_do_wr   = i_wr_en && !w_full && !i_flush;
   assign w_do_pop  = i_pop && !w_empty && !i_flush;
   // Fullness is judged before any same-cycle pop, so a write while full is
   // dropped even when a pop frees a slot in that cycle.
   assign w_wr_drop = i_wr_en && w_full && !i_flush;

   // Storage carries no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (w_do_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_do_wr) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            // Pop only happens with count > 0 and writes only with
            // count < DEPTH, so the read slot never equals the write slot.
            if (w_do_pop) begin
               r_rd_ptr  <= r_rd_ptr + 1'b1;
               r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_pop})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end

         // Set has priority over clear so a drop is never lost.
         if (w_wr_drop) begin
            r_overflow <= 1'b1;
         end else if (i_ovf_clr) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_full     = w_full;
   assign o_empty    = w_empty;
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Buffers bytes from game/control logic and launches them one at a time into
// the UART transmitter, waiting for tx_done_tick between frames.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset (shared with the transmitter)
//   bus      : uart_tx_feeder_if.slave
//              wr_en/wr_data/flush/ovf_clr in, full/empty/count/overflow out,
//              tx_start/tx_data out, tx_done_tick in, busy/timeout_err out
// Build option:
//   UART_TX_FEEDER_TIMEOUT_EN : enables the frame watchdog. After
//   TIMEOUT_CYCLES cycles in BUSY without tx_done_tick the frame is abandoned
//   and timeout_err pulses. Without it timeout_err is held low and BUSY waits
//   for tx_done_tick indefinitely.
// -----------------------------------------------------------------------------
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2     = FIFO_DEPTH_LOG2,
   parameter int DATA_W         = DBIT,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   uart_tx_feeder_if.slave  bus
);

   feed_state_t         r_state;
   logic                r_tx_start;
   logic                w_pop;
   logic                w_empty;
   logic                w_wd_expired;
   logic [DATA_W-1:0]   w_rd_data;

   // Launch whenever idle with data waiting; flush suppresses the pop.
   assign w_pop = (r_state == FEED_IDLE) && !w_empty && !bus.flush;

   // The FIFO's registered read port doubles as the tx_data register: it
   // loads only on a launch, so the byte stays stable for the whole frame.
   uart_sync_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_wr_en    (bus.wr_en),
      .i_wr_data  (bus.wr_data),
      .i_flush    (bus.flush),
      .i_ovf_clr  (bus.ovf_clr),
      .i_pop      (w_pop),
      .o_rd_data  (w_rd_data),
      .o_full     (bus.full),
      .o_empty    (w_empty),
      .o_count    (bus.count),
      .o_overflow (bus.overflow)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= FEED_IDLE;
         r_tx_start <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         if (r_state == FEED_IDLE) begin
            if (w_pop) begin
               r_state    <= FEED_BUSY;
               r_tx_start <= 1'b1;
            end
         end else begin
            // Flush leaves the in-flight frame alone; only the transmitter
            // (or the watchdog) ends BUSY.
            if (bus.tx_done_tick || w_wd_expired) begin
               r_state <= FEED_IDLE;
            end
         end
      end
   end

`ifdef UART_TX_FEEDER_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0]  r_wd_cnt;
   logic             r_timeout_err;

   // The counter holds k after the k-th BUSY edge, so the abort lands exactly
   // TIMEOUT_CYCLES edges after the launch. A done tick in that same cycle
   // ends the frame normally instead.
   assign w_wd_expired = (r_state == FEED_BUSY) && !bus.tx_done_tick &&
                         (r_wd_cnt == WD_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_wd_expired;
         if (w_pop) begin
            r_wd_cnt <= '0;
         end else if ((r_state == FEED_BUSY) && !w_wd_expired) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
         end
      end
   end

   assign bus.timeout_err = r_timeout_err;
`else
   assign w_wd_expired    = 1'b0;
   // Watchdog compiled out; the parameter is still referenced so the
   // interface of the block is identical in both builds.
   assign bus.timeout_err = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   assign bus.empty    = w_empty;
   assign bus.tx_start = r_tx_start;
   assign bus.tx_data  = w_rd_data;
   assign bus.busy     = (r_state == FEED_BUSY);

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DEPTH_LOG2(4), .DATA_W(8)) bus ();

   uart_tx_feeder #(
      .DEPTH_LOG2     (4),
      .DATA_W         (8),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] exp_q[$];
   int n_starts = 0;
   int n_to = 0;
   int max_count = 0;
   int last_done_cyc = -1;
   int last_start_cyc = -1;
   int last_to_cyc = -1;
   bit chk_gap = 1'b0;

   // transmitter model
   logic done_man = 1'b0;
   logic done_auto = 1'b0;
   bit xmit_auto = 1'b0;
   int frame_len = 20;
   int frame_left = 0;
   assign bus.tx_done_tick = done_man | done_auto;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         done_auto = 1'b0;
         if (xmit_auto) begin
            if (bus.tx_start) frame_left = frame_len;
            else if (frame_left > 0) begin
               frame_left--;
               if (frame_left == 0) begin
                  done_auto = 1'b1;
                  last_done_cyc = cyc;
               end
            end
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         if (!reset_n) continue;
         if (int'(bus.count) > max_count) max_count = int'(bus.count);
         if (bus.tx_start) begin
            n_starts++;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_tx_start: got tx_data=%0h, required no launch", bus.tx_data);
            end else begin
               exp_b = exp_q.pop_front();
               check("tx_data", 32'(bus.tx_data), 32'(exp_b));
               check("busy_at_start", 32'(bus.busy), 32'd1);
            end
            if (chk_gap && last_done_cyc >= 0) begin
               check("done_to_start_gap", 32'(cyc - last_done_cyc), 32'd2);
               last_done_cyc = -1;
            end
            if (last_to_cyc >= 0) begin
               check("timeout_relaunch_gap", 32'(cyc - last_to_cyc), 32'd1);
               last_to_cyc = -1;
            end
            last_start_cyc = cyc;
         end
         if (bus.timeout_err) begin
`ifdef UART_TX_FEEDER_TIMEOUT_EN
            n_to++;
            check("timeout_delay", 32'(cyc - last_start_cyc), 32'd50);
            check("busy_after_timeout", 32'(bus.busy), 32'd0);
            last_to_cyc = cyc;
`else
            n_vec++;
            n_err++;
            $display("FAIL unexpected_timeout_err: got 1, required 0");
`endif
         end
      end
   end

   task automatic drive(input logic we, input logic [7:0] d, input logic fl,
                        input logic oc, input logic push);
      bus.wr_en = we;
      bus.wr_data = d;
      bus.flush = fl;
      bus.ovf_clr = oc;
      if (push) exp_q.push_back(d);
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.flush = 1'b0;
      bus.ovf_clr = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] d, input logic push);
      drive(1'b1, d, 1'b0, 1'b0, push);
   endtask

   task automatic pulse_done();
      done_man = 1'b1;
      @(negedge clk);
      done_man = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while (!(bus.busy == 1'b0 && bus.empty == 1'b1 && exp_q.size() == 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(n < budget), 32'd1);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      int s0;
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      bus.flush = 1'b0;
      bus.ovf_clr = 1'b0;

      // ---- reset values
      idle(2);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      check("rst_tx_start", 32'(bus.tx_start), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
      reset_n = 1'b1;
      idle(2);

      // ---- 1: single byte, latency, hold-off
      write_byte(8'hA5, 1'b1);
      check("t1_enqueue_count", 32'(bus.count), 32'd1);
      check("t1_no_early_start", 32'(bus.tx_start), 32'd0);
      @(negedge clk);
      check("t1_start_latency", 32'(bus.tx_start), 32'd1);
      check("t1_empty_after_pop", 32'(bus.empty), 32'd1);
      idle(10);
      check("t1_busy_held", 32'(bus.busy), 32'd1);
      check("t1_tx_data_stable", 32'(bus.tx_data), 32'hA5);
      pulse_done();
      check("t1_busy_clear", 32'(bus.busy), 32'd0);
      check("t1_empty", 32'(bus.empty), 32'd1);
      idle(3);

      // ---- 2: 16-byte burst, 20-cycle frames
      xmit_auto = 1'b1;
      frame_len = 20;
      last_done_cyc = -1;
      chk_gap = 1'b1;
      max_count = 0;
      s0 = n_starts;
      for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
      wait_drain(16 * 24 + 40, "t2_drain");
      chk_gap = 1'b0;
      last_done_cyc = -1;
      check("t2_launches", 32'(n_starts - s0), 32'd16);
      check("t2_max_count_le16", 32'(max_count <= 16), 32'd1);

      // ---- 3: overflow with transmitter held busy
      xmit_auto = 1'b0;
      write_byte(8'hEE, 1'b1);
      for (int i = 0; i < 16; i++) write_byte(8'(8'h30 + i), 1'b1);
      check("t3_full", 32'(bus.full), 32'd1);
      check("t3_count16", 32'(bus.count), 32'd16);
      check("t3_no_ovf_yet", 32'(bus.overflow), 32'd0);
      write_byte(8'h40, 1'b0);
      check("t3_overflow_set", 32'(bus.overflow), 32'd1);
      check("t3_count_still16", 32'(bus.count), 32'd16);
      idle(5);
      check("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
      drive(1'b1, 8'h41, 1'b0, 1'b1, 1'b0);
      check("t3_set_wins", 32'(bus.overflow), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("t3_ovf_clr2", 32'(bus.overflow), 32'd0);
      s0 = n_starts;
      frame_len = 4;
      xmit_auto = 1'b1;
      pulse_done();
      wait_drain(16 * 8 + 40, "t3_drain");
      check("t3_launches", 32'(n_starts - s0), 32'd16);

      // ---- 4a: pop and write in the same cycle
      xmit_auto = 1'b0;
      idle(2);
      write_byte(8'h50, 1'b1);
      for (int i = 1; i <= 5; i++) write_byte(8'(8'h50 + i), 1'b1);
      check("t4_count5_busy", 32'(bus.count), 32'd5);
      pulse_done();
      check("t4_idle", 32'(bus.busy), 32'd0);
      check("t4_count5_idle", 32'(bus.count), 32'd5);
      write_byte(8'h56, 1'b1);
      check("t4_pop_wr_count", 32'(bus.count), 32'd5);
      check("t4_pop_launched", 32'(bus.tx_start), 32'd1);
      // ---- 4b: flush with write while full and busy
      for (int i = 0; i < 11; i++) write_byte(8'(8'h57 + i), 1'b1);
      check("t4_full", 32'(bus.full), 32'd1);
      exp_q.delete();
      drive(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
      check("t4_flush_count", 32'(bus.count), 32'd0);
      check("t4_flush_empty", 32'(bus.empty), 32'd1);
      check("t4_flush_no_ovf", 32'(bus.overflow), 32'd0);
      check("t4_flush_keeps_busy", 32'(bus.busy), 32'd1);
      idle(3);
      pulse_done();
      idle(10);
      check("t4_final_idle", 32'(bus.busy), 32'd0);

      // ---- 5: reset while busy
      write_byte(8'h70, 1'b1);
      for (int i = 1; i <= 3; i++) write_byte(8'(8'h70 + i), 1'b1);
      check("t5_count3", 32'(bus.count), 32'd3);
      check("t5_busy", 32'(bus.busy), 32'd1);
      check("t5_tx_data", 32'(bus.tx_data), 32'h70);
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("t5_rst_count", 32'(bus.count), 32'd0);
      check("t5_rst_empty", 32'(bus.empty), 32'd1);
      check("t5_rst_busy", 32'(bus.busy), 32'd0);
      check("t5_rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("t5_rst_tx_start", 32'(bus.tx_start), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      idle(10);
      check("t5_stays_idle", 32'(bus.busy), 32'd0);
      xmit_auto = 1'b1;
      write_byte(8'h7A, 1'b1);
      wait_drain(40, "t5_new_write_drain");

`ifdef UART_TX_FEEDER_TIMEOUT_EN
      // ---- 6: watchdog
      xmit_auto = 1'b0;
      idle(2);
      n_to = 0;
      write_byte(8'h90, 1'b1);
      write_byte(8'h91, 1'b1);
      begin
         int n = 0;
         while (!(n_to == 2 && bus.busy == 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
         end
      end
      check("t6_timeouts", 32'(n_to), 32'd2);
      check("t6_final_idle", 32'(bus.busy), 32'd0);
`endif

      idle(5);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
